mdu_hilo: RTL
=============

# mdu_hilo

Iterative-latency multiply/divide unit for the Execute stage: it is the writer of the HI/LO register pair that the Writeback stage reads for `mfhi`/`mflo`. It accepts a single-cycle start request, holds `busy` for a fixed per-operation latency, then commits the 64-bit result to HI/LO. Upstream hazard logic uses `start | busy` to stall `mult`/`div`/`mfhi`/`mflo`/`mthi`/`mtlo` in D.

## Interface
- `MULT_CYCLES`, default 5: latency of MULT/MULTU/MADD/MADDU in cycles.
- `DIV_CYCLES`, default 10: latency of DIV/DIVU in cycles.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle request; sampled with `op`, `A` and `B`.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `busy`  out  1  operation in flight.
- `HI`  out  32  HI register, fed forward to M/W for `mfhi`.
- `LO`  out  32  LO register, fed forward to M/W for `mflo`.

## Operation
- Internal state:
  - `cnt` (4+ bits, wide enough for `max(MULT_CYCLES, DIV_CYCLES)`).
  - Pending result registers `res_hi` and `res_lo`.
  - `commit_en` flag.
- States:
  - IDLE (`cnt==0`, `busy=0`).
  - RUN (`cnt!=0`, `busy=1`).
- IDLE and `start` with op 0/1/6/7:
  - Computes the 64-bit product into `res_*`: signed for 0/6, unsigned for 1/7.
  - For op 6/7 the result is `{HI,LO}` + product, as a 64-bit sum with wrap-around and no overflow trap.
  - Sets `cnt=MULT_CYCLES`, `commit_en=1`.
- IDLE and `start` with op 2/3:
  - `res_lo` = quotient, `res_hi` = remainder.
  - Signed for op 2: truncation toward zero, remainder takes the sign of the dividend. Unsigned for op 3.
  - Sets `cnt=DIV_CYCLES`.
  - `B==0`: `commit_en=0`. Busy still runs the full DIV_CYCLES, and HI/LO stay unchanged.
  - Signed `0x80000000 / -1`: LO=0x80000000, HI=0.
- IDLE and `start` with op 4/5: HI (op 4) or LO (op 5) := `A` at that edge. `busy` stays 0.
- RUN:
  - Each edge decrements `cnt`.
  - On the edge where `cnt==1`: if `commit_en`, HI := `res_hi` and LO := `res_lo`. `cnt` becomes 0.
- `start` while RUN: ignored entirely, for every op. The pipeline never issues this; it must not corrupt the in-flight result.
- Reset (`reset==0` at an edge), including mid-operation: HI=0, LO=0, `cnt=0`, `busy=0`, `commit_en=0`. The in-flight result is discarded.

## Timing
- Reset values: `busy=0`, `HI=0`, `LO=0`.
- `start` accepted at edge t with latency N:
  - `busy=1` during cycles t+1 … t+N.
  - HI/LO hold their new values from edge t+N onward, so they are valid in the first cycle with `busy=0`.
- MTHI/MTLO: zero stall, visible the cycle after the edge.
- A new `start` is accepted in the cycle `busy` drops, i.e. back-to-back operations have no gap.
- `busy` is a pure register output. HI/LO are register outputs with no combinational path from inputs.

## Configuration
- `MDU_MADD_EN`:
  - Defined: ops 6/7 (MADD/MADDU) are implemented as above.
  - Undefined: ops 6/7 are treated as no-ops. No busy, HI/LO unchanged. The accumulate adder is not synthesized.

## Test plan
- Reset held low for 2 cycles mid-DIV → `busy=0`, HI=LO=0 on the next cycle; no commit afterwards.
- MULT A=0xFFFFFFFF (−1), B=2 →
  - `busy` high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=−7 (0xFFFFFFF9), B=2 →
  - `busy` 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
- DIVU A=5, B=0 after MTHI 0x1234 and MTLO 0x5678 → `busy` 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- MULT 3×4 started, then `start` with MTLO A=0xDEAD asserted at cycle 2 of busy → ignored; final LO=12, HI=0.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Without it → HI/LO unchanged, `busy` never asserts.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the HI/LO register pair, with fixed per-op latency.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module mdu_hilo #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_BITS   = $clog2(MAX_CYCLES + 1);
   localparam int CNT_W      = (CNT_BITS < 4) ? 4 : CNT_BITS;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_next_s;
   logic               commit_en_r;
   logic               commit_en_next_s;
   logic [31:0]        res_hi_r;
   logic [31:0]        res_lo_r;
   logic [31:0]        res_hi_next_s;
   logic [31:0]        res_lo_next_s;
   logic [31:0]        hi_r;
   logic [31:0]        lo_r;
   logic [31:0]        hi_next_s;
   logic [31:0]        lo_next_s;

   logic [63:0]        mul_a_s;
   logic [63:0]        mul_b_s;
   logic [63:0]        product_s;
   logic               div_signed_s;
   logic               a_neg_s;
   logic               b_neg_s;
   logic [31:0]        abs_a_s;
   logic [31:0]        abs_b_s;
   logic [31:0]        div_b_s;
   logic [31:0]        q_mag_s;
   logic [31:0]        r_mag_s;
   logic [31:0]        quotient_s;
   logic [31:0]        remainder_s;
`ifdef MDU_MADD_EN
   logic [63:0]        acc_s;
`endif

   // Multiplier: sign-extend for op[0]==0 (MULT/MADD); the low 64 bits of the product are exact either way.
   always_comb begin
      if (op[0] == 1'b0) begin
         mul_a_s = {{32{A[31]}}, A};
         mul_b_s = {{32{B[31]}}, B};
      end else begin
         mul_a_s = {32'd0, A};
         mul_b_s = {32'd0, B};
      end
      product_s = mul_a_s * mul_b_s;
   end

`ifdef MDU_MADD_EN
   // Accumulate path: 64-bit wrap-around sum with the current HI/LO.
   always_comb begin
      acc_s = {hi_r, lo_r} + product_s;
   end
`endif

   // Divider on magnitudes so that 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
   always_comb begin
      div_signed_s = ~op[0];
      a_neg_s      = div_signed_s & A[31];
      b_neg_s      = div_signed_s & B[31];
      abs_a_s      = a_neg_s ? (~A + 32'd1) : A;
      abs_b_s      = b_neg_s ? (~B + 32'd1) : B;
      div_b_s      = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
      q_mag_s      = abs_a_s / div_b_s;
      r_mag_s      = abs_a_s % div_b_s;
      quotient_s   = (a_neg_s ^ b_neg_s) ? (~q_mag_s + 32'd1) : q_mag_s;
      remainder_s  = a_neg_s ? (~r_mag_s + 32'd1) : r_mag_s;
   end

   // State register: countdown, pending result and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         commit_en_r <= 1'b0;
         res_hi_r    <= 32'd0;
         res_lo_r    <= 32'd0;
         hi_r        <= 32'd0;
         lo_r        <= 32'd0;
      end else begin
         state_r     <= state_next_s;
         cnt_r       <= cnt_next_s;
         commit_en_r <= commit_en_next_s;
         res_hi_r    <= res_hi_next_s;
         res_lo_r    <= res_lo_next_s;
         hi_r        <= hi_next_s;
         lo_r        <= lo_next_s;
      end
   end

   // Next-state logic: accept requests only in IDLE, count down and commit in RUN.
   always_comb begin
      cnt_next_s       = cnt_r;
      commit_en_next_s = commit_en_r;
      res_hi_next_s    = res_hi_r;
      res_lo_next_s    = res_lo_r;
      hi_next_s        = hi_r;
      lo_next_s        = lo_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  3'd0, 3'd1: begin
                     res_hi_next_s    = product_s[63:32];
                     res_lo_next_s    = product_s[31:0];
                     commit_en_next_s = 1'b1;
                     cnt_next_s       = CNT_W'(MULT_CYCLES);
                  end
                  3'd2, 3'd3: begin
                     res_hi_next_s    = remainder_s;
                     res_lo_next_s    = quotient_s;
                     commit_en_next_s = (B != 32'd0);
                     cnt_next_s       = CNT_W'(DIV_CYCLES);
                  end
                  3'd4: begin
                     hi_next_s = A;
                  end
                  3'd5: begin
                     lo_next_s = A;
                  end
`ifdef MDU_MADD_EN
                  3'd6, 3'd7: begin
                     res_hi_next_s    = acc_s[63:32];
                     res_lo_next_s    = acc_s[31:0];
                     commit_en_next_s = 1'b1;
                     cnt_next_s       = CNT_W'(MULT_CYCLES);
                  end
`endif
                  default: begin
                     cnt_next_s = {CNT_W{1'b0}};
                  end
               endcase
            end else begin
               cnt_next_s = {CNT_W{1'b0}};
            end
         end
         ST_RUN: begin
            cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            if ((cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) && commit_en_r) begin
               hi_next_s = res_hi_r;
               lo_next_s = res_lo_r;
            end else begin
               hi_next_s = hi_r;
               lo_next_s = lo_r;
            end
         end
         default: begin
            cnt_next_s       = {CNT_W{1'b0}};
            commit_en_next_s = 1'b0;
         end
      endcase
      state_next_s = (cnt_next_s != {CNT_W{1'b0}}) ? ST_RUN : ST_IDLE;
   end

   // Outputs are taken straight from registers.
   always_comb begin
      busy = (state_r == ST_RUN);
      HI   = hi_r;
      LO   = lo_r;
   end

endmodule
